// File: rtl/fifo_wr_ptr_full_if.sv
// Write-side bus of the async FIFO pointer controller: producer request,
// synchronized read pointer in, memory write port and status flags out.
interface fifo_wr_ptr_full_if #(
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  w_inc;
    logic                  ovf_clr;
    logic [ADDR_WIDTH:0]   sync_rd_ptr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  wr_en;
    logic [ADDR_WIDTH:0]   gray_wr_ptr;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   free_cnt;
    logic                  overflow;

    modport master (
        output w_inc, ovf_clr, sync_rd_ptr,
        input  w_addr, wr_en, gray_wr_ptr, full, almost_full, free_cnt, overflow
    );

    modport slave (
        input  w_inc, ovf_clr, sync_rd_ptr,
        output w_addr, wr_en, gray_wr_ptr, full, almost_full, free_cnt, overflow
    );
endinterface

// File: rtl/fifo_wr_ptr_full.sv
// Write-domain pointer and status controller of the async FIFO: binary/Gray
// write pointer, registered full/almost-full/free-count and sticky overflow.
module fifo_wr_ptr_full #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_THRESH  = 2
) (
    input logic               clk,
    input logic               rst_n,
    fifo_wr_ptr_full_if.slave bus
);
    localparam int unsigned PtrW  = ADDR_WIDTH + 1;
    localparam int unsigned Depth = 1 << ADDR_WIDTH;
    // Inverting the top two Gray bits of the read pointer gives the write
    // pointer value that sits exactly one full lap ahead of it.
    localparam logic [PtrW-1:0] FullMask = PtrW'(3) << (PtrW - 2);

    logic [PtrW-1:0] wbin_q, wbin_d;
    logic [PtrW-1:0] gray_q, gray_d;
    logic [PtrW-1:0] free_q, free_d;
    logic [PtrW-1:0] rbin;
    logic            full_q, full_d;
    logic            af_q, af_d;
    logic            ovf_q, ovf_d;
    logic            accept;

    assign accept = bus.w_inc & ~full_q;

    always_comb begin
        rbin = '0;
        for (int i = 0; i < PtrW; i++) begin
            rbin[i] = ^(bus.sync_rd_ptr >> i);
        end
    end

    always_comb begin
        wbin_d = accept ? wbin_q + PtrW'(1) : wbin_q;
        gray_d = wbin_d ^ (wbin_d >> 1);
        full_d = (gray_d == (bus.sync_rd_ptr ^ FullMask));
        free_d = PtrW'(Depth) - (wbin_d - rbin);
        af_d   = (free_d <= PtrW'(AF_THRESH));
        // Set takes priority over clear.
        ovf_d  = (bus.w_inc & full_q) | (ovf_q & ~bus.ovf_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q <= '0;
            gray_q <= '0;
            full_q <= 1'b0;
            af_q   <= 1'b0;
            free_q <= PtrW'(Depth);
            ovf_q  <= 1'b0;
        end else begin
            wbin_q <= wbin_d;
            gray_q <= gray_d;
            full_q <= full_d;
            af_q   <= af_d;
            free_q <= free_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.wr_en       = accept;
    assign bus.w_addr      = wbin_q[ADDR_WIDTH-1:0];
    assign bus.gray_wr_ptr = gray_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.free_cnt    = free_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// Directed bench for fifo_wr_ptr_full with ADDR_WIDTH=3, AF_THRESH=2 (depth 8).
module tb_fifo_wr_ptr_full;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    fifo_wr_ptr_full_if #(.ADDR_WIDTH(3)) bus ();

    fifo_wr_ptr_full #(.ADDR_WIDTH(3), .AF_THRESH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [3:0] gtab [8] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
    logic [3:0] model_w, wnext, d0, d1, d2, exp_free, prev_gray;

    initial begin
        bus.w_inc       = 1'b0;
        bus.ovf_clr     = 1'b0;
        bus.sync_rd_ptr = '0;
        #12;
        chk("rst_free", bus.free_cnt, 8);
        chk("rst_gray", bus.gray_wr_ptr, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_af", bus.almost_full, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_waddr", bus.w_addr, 0);
        chk("rst_wren", bus.wr_en, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill all eight slots with the read pointer parked at 0.
        for (int i = 0; i < 8; i++) begin
            bus.w_inc = 1'b1;
            #1;
            chk("fill_waddr", bus.w_addr, i);
            chk("fill_wren", bus.wr_en, 1);
            @(negedge clk);
            chk("fill_gray", bus.gray_wr_ptr, gtab[i]);
            chk("fill_free", bus.free_cnt, 7 - i);
            chk("fill_af", bus.almost_full, (7 - i) <= 2);
            chk("fill_full", bus.full, i == 7);
        end

        // Writes while full are dropped and flagged.
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ovf_wren", bus.wr_en, 0);
            @(negedge clk);
            chk("ovf_gray", bus.gray_wr_ptr, 12);
            chk("ovf_flag", bus.overflow, 1);
            chk("ovf_full", bus.full, 1);
        end
        bus.w_inc   = 1'b0;
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        chk("ovf_clr", bus.overflow, 0);

        // Reader has consumed three entries.
        bus.sync_rd_ptr = 4'd2;
        @(negedge clk);
        chk("rd3_full", bus.full, 0);
        chk("rd3_free", bus.free_cnt, 3);
        chk("rd3_af", bus.almost_full, 0);
        for (int i = 0; i < 3; i++) begin
            bus.w_inc = 1'b1;
            #1;
            chk("wrap_waddr", bus.w_addr, i);
            @(negedge clk);
        end
        chk("wrap_full", bus.full, 1);
        chk("wrap_free", bus.free_cnt, 0);
        chk("wrap_gray", bus.gray_wr_ptr, 14);

        // Set and clear in the same cycle: set wins.
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        chk("setwin_ovf", bus.overflow, 1);
        chk("setwin_gray", bus.gray_wr_ptr, 14);
        bus.w_inc = 1'b0;
        @(negedge clk);
        chk("clr_ovf", bus.overflow, 0);
        bus.ovf_clr = 1'b0;

        // Fresh start for streaming: read pointer trails by three cycles.
        rst_n = 1'b0;
        bus.sync_rd_ptr = '0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        model_w   = '0;
        d0        = '0;
        d1        = '0;
        d2        = '0;
        prev_gray = '0;
        for (int n = 0; n < 40; n++) begin
            bus.sync_rd_ptr = gray(d2);
            bus.w_inc = 1'b1;
            #1;
            chk("strm_waddr", bus.w_addr, model_w[2:0]);
            @(posedge clk);
            wnext    = model_w + 4'd1;
            exp_free = 4'd8 - (wnext - d2);
            d2 = d1;
            d1 = d0;
            d0 = wnext;
            model_w = wnext;
            @(negedge clk);
            chk("strm_gray", bus.gray_wr_ptr, gray(model_w));
            chk("strm_onebit", $countones(bus.gray_wr_ptr ^ prev_gray), 1);
            chk("strm_full", bus.full, 0);
            chk("strm_free", bus.free_cnt, exp_free);
            prev_gray = bus.gray_wr_ptr;
        end
        bus.w_inc = 1'b0;

        // Reset in the middle of a fill.
        rst_n = 1'b0;
        bus.sync_rd_ptr = '0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        bus.w_inc = 1'b1;
        repeat (5) @(negedge clk);
        bus.w_inc = 1'b0;
        chk("mid_free", bus.free_cnt, 3);
        chk("mid_gray", bus.gray_wr_ptr, 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_free", bus.free_cnt, 8);
        chk("arst_gray", bus.gray_wr_ptr, 0);
        chk("arst_full", bus.full, 0);
        chk("arst_waddr", bus.w_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_wr_ptr_full.md
Name: fifo_wr_ptr_full

Overview:
- Write-domain pointer and status controller for the async FIFO.
- Advances the binary write pointer on accepted writes and drives the FIFO memory write address/enable.
- Publishes the Gray-coded write pointer; the read-domain 2-FF pointer synchronizer consumes it.
- Takes the already-synchronized Gray read pointer and produces registered FULL, ALMOST_FULL, free-space count and a sticky overflow flag.

Parameters:
- ADDR_WIDTH, 3, memory address width; FIFO depth DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AF_THRESH, 2, ALMOST_FULL asserts when free entries <= AF_THRESH; legal range 1..DEPTH-1.

Ports:
- CLK  in  1  write-domain clock.
- RST  in  1  asynchronous active-low reset.
- W_INC  in  1  write request from the producer.
- OVF_CLR  in  1  synchronous clear of OVERFLOW.
- SYNC_RD_PTR  in  ADDR_WIDTH+1  Gray read pointer, already synchronized into CLK.
- W_ADDR  out  ADDR_WIDTH  memory write address.
- WR_EN  out  1  memory write enable.
- GRAY_WR_PTR  out  ADDR_WIDTH+1  registered Gray write pointer to the read-side synchronizer.
- FULL  out  1  FIFO full (registered).
- ALMOST_FULL  out  1  free entries <= AF_THRESH (registered).
- FREE_CNT  out  ADDR_WIDTH+1  free entries, 0..DEPTH (registered).
- OVERFLOW  out  1  sticky: a write was attempted while FULL.

Behaviour:
- Reset (RST low, async): wbin=0, GRAY_WR_PTR=0, FULL=0, ALMOST_FULL=0, FREE_CNT=DEPTH, OVERFLOW=0. W_ADDR=0 and WR_EN=0 follow from this.
- Accept: WR_EN = W_INC & ~FULL. Combinational; the only combinational output.
- W_ADDR = wbin[ADDR_WIDTH-1:0], taken directly from the register.
- Data for an accepted write is written at the current W_ADDR in the same cycle.
- Pointer update: on an accepted write, wbin_next = wbin + 1 with natural wrap modulo 2**(ADDR_WIDTH+1); otherwise wbin_next = wbin.
- GRAY_WR_PTR <= wbin_next ^ (wbin_next >> 1). Registered, so exactly one bit changes per increment, as the synchronizer requires.
- Full: FULL <= (gray_next == {~SYNC_RD_PTR[MSB:MSB-1], SYNC_RD_PTR[MSB-2:0]}).
  - With ADDR_WIDTH=1 this is the inversion of both pointer bits.
  - FULL asserts in the cycle after the write that fills the last slot.
- Free count:
  - rbin = gray-to-binary(SYNC_RD_PTR), a combinational XOR prefix from the MSB.
  - FREE_CNT <= DEPTH - ((wbin_next - rbin) mod 2**(ADDR_WIDTH+1)).
  - ALMOST_FULL <= (that value <= AF_THRESH).
  - FULL and FREE_CNT==0 are always consistent in the same cycle.
- Pessimism: SYNC_RD_PTR lags the true read pointer by 2+ cycles.
  - FULL, ALMOST_FULL and FREE_CNT are conservative: they report no more free space than actually exists.
  - They deassert 1 cycle after a new SYNC_RD_PTR value arrives. This is correct behaviour, not a bug.
- Overflow: W_INC & FULL sets OVERFLOW on the next edge. The pointer does not move and WR_EN stays 0.
  - OVF_CLR clears it on the next edge.
  - If the set condition and OVF_CLR occur in the same cycle, set wins.
- Simultaneous events: a write acceptance and a SYNC_RD_PTR change in the same cycle are both reflected in the next-cycle FULL/FREE_CNT.
- Wrap-around: pointers wrap after 2*DEPTH writes. FULL/empty distinction relies on the extra MSB; no special case is needed.
- Reset mid-operation: all state returns to reset values immediately. The read domain must be reset together with this block; this block does not coordinate that.
- No state machine beyond the pointer/flag registers. Everything is a single-cycle registered update.

Test Plan (ADDR_WIDTH=3, AF_THRESH=2, DEPTH=8):
- Reset, then W_INC held 8 cycles with SYNC_RD_PTR=0:
  - W_ADDR steps 0..7; GRAY_WR_PTR sequence 1,3,2,6,7,5,4,12.
  - ALMOST_FULL rises after write 6 (FREE_CNT=2); FULL=1 and FREE_CNT=0 after write 8.
- While FULL, W_INC held 3 cycles:
  - WR_EN=0; pointer stays at 8 (Gray 12); OVERFLOW=1 and stays 1.
  - Pulse OVF_CLR: OVERFLOW=0 on the next edge.
- From full, drive SYNC_RD_PTR=Gray(3)=2:
  - One cycle later FULL=0, FREE_CNT=3, ALMOST_FULL=0.
  - Three further writes: FULL=1, W_ADDR wrapped to 0,1,2.
- Continuous write/read for 40 entries, with SYNC_RD_PTR following wptr delayed by 3 cycles:
  - Pointer wraps past 15→0 without a false FULL.
  - GRAY_WR_PTR changes by exactly one bit per increment; FREE_CNT is never above the true free count.
- Same cycle W_INC=1, FULL=1 and OVF_CLR=1 → OVERFLOW=1 (set wins).
- Assert RST at mid-fill (5 entries):
  - Outputs return to reset values asynchronously before the next edge: FREE_CNT=8, GRAY_WR_PTR=0, FULL=0.
